// File: rtl/pwxc_stream_driver.sv
// Feeds buffer A then buffer B to a correlator as one contiguous stream and
// collects the signed result, with a bounded wait and a sticky timeout flag.
module pwxc_stream_driver #(
  parameter int M          = 3,
  parameter int N          = 3,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 64,
  localparam int MAX_MN    = (M > N) ? M : N,
  localparam int AW        = (MAX_MN > 1) ? $clog2(MAX_MN) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [AW-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    start,
  output logic                    valid_in_A,
  output logic                    valid_in_B,
  output logic [DATA_WIDTH-1:0]   a_out,
  output logic [DATA_WIDTH-1:0]   b_out,
  input  logic                    corr_valid,
  input  logic [2*DATA_WIDTH-1:0] corr_in,
  output logic                    busy,
  output logic [2*DATA_WIDTH-1:0] result,
  output logic                    done,
  output logic                    timeout_err
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW-1:0] A_LAST    = AW'(M - 1);
  localparam logic [AW-1:0] B_LAST    = AW'(N - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SEND_A   = 2'd1;
  localparam logic [1:0] SEND_B   = 2'd2;
  localparam logic [1:0] WAIT_RES = 2'd3;

  logic [1:0]            state;
  logic [AW-1:0]         idx;
  logic [AW-1:0]         idx_next;
  logic [WW-1:0]         wait_cnt;
  logic [DATA_WIDTH-1:0] buf_a [M];
  logic [DATA_WIDTH-1:0] buf_b [N];

  assign idx_next = idx + AW'(1);

  // Sample buffers only accept writes between transactions, so a stream is never torn.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < M; i++) buf_a[i] <= '0;
      for (int i = 0; i < N; i++) buf_b[i] <= '0;
    end else if (wr_en && !busy) begin
      if (!wr_sel && (wr_addr <= A_LAST)) buf_a[wr_addr] <= wr_data;
      if (wr_sel && (wr_addr <= B_LAST))  buf_b[wr_addr] <= wr_data;
    end
  end

  // Outputs are loaded on the same edge that enters each step, so they line up with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      wait_cnt    <= '0;
      valid_in_A  <= 1'b0;
      valid_in_B  <= 1'b0;
      a_out       <= '0;
      b_out       <= '0;
      busy        <= 1'b0;
      result      <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= SEND_A;
            idx         <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            valid_in_A  <= 1'b1;
            valid_in_B  <= 1'b0;
            a_out       <= buf_a[0];
            b_out       <= '0;
          end
        end
        SEND_A: begin
          if (idx == A_LAST) begin
            state      <= SEND_B;
            idx        <= '0;
            valid_in_B <= 1'b1;
            a_out      <= '0;
            b_out      <= buf_b[0];
          end else begin
            idx   <= idx_next;
            a_out <= buf_a[idx_next];
          end
        end
        SEND_B: begin
          if (idx == B_LAST) begin
            state      <= WAIT_RES;
            wait_cnt   <= '0;
            valid_in_A <= 1'b0;
            valid_in_B <= 1'b0;
            b_out      <= '0;
          end else begin
            idx   <= idx_next;
            b_out <= buf_b[idx_next];
          end
        end
        WAIT_RES: begin
          // A result arriving on the last permitted cycle still counts as success.
          if (corr_valid) begin
            result <= corr_in;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          valid_in_A <= 1'b0;
          valid_in_B <= 1'b0;
          a_out      <= '0;
          b_out      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwxc_stream_driver.sv
// Randomized and directed bench for pwxc_stream_driver, checked every cycle
// against a transaction-level reference model built from cycle offsets.
module tb_pwxc_stream_driver;

  localparam int M       = 3;
  localparam int N       = 3;
  localparam int DW      = 16;
  localparam int TIMEOUT = 64;
  localparam int AW      = 2;
  localparam int LEN     = M + N;

  logic            clk        = 1'b0;
  logic            reset      = 1'b1;
  logic            wr_en      = 1'b0;
  logic            wr_sel     = 1'b0;
  logic [AW-1:0]   wr_addr    = '0;
  logic [DW-1:0]   wr_data    = '0;
  logic            start      = 1'b0;
  logic            corr_valid = 1'b0;
  logic [2*DW-1:0] corr_in    = '0;
  logic            valid_in_A, valid_in_B, busy, done, timeout_err;
  logic [DW-1:0]   a_out, b_out;
  logic [2*DW-1:0] result;

  int errors = 0;
  int checks = 0;

  pwxc_stream_driver #(.M(M), .N(N), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .valid_in_A(valid_in_A), .valid_in_B(valid_in_B),
    .a_out(a_out), .b_out(b_out), .corr_valid(corr_valid), .corr_in(corr_in),
    .busy(busy), .result(result), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: a transaction is a cycle offset c from the accepted start.
  logic [DW-1:0]   m_buf_a [M];
  logic [DW-1:0]   m_buf_b [N];
  bit              m_busy, m_va, m_vb, m_done, m_to;
  int              m_c;
  logic [DW-1:0]   m_a, m_b;
  logic [2*DW-1:0] m_result;

  int              resp_delay  = -1;
  logic [2*DW-1:0] resp_value  = '0;
  bit              spurious_en = 1'b0;
  bit              capture_on  = 1'b0;
  int              done_count  = 0;
  int              busy_cycles = 0;
  logic [DW-1:0]   cap_a [$];
  logic [DW-1:0]   cap_b [$];
  bit              cap_vb [$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_clear();
    m_busy = 0; m_va = 0; m_vb = 0; m_done = 0; m_to = 0; m_c = 0;
    m_a = '0; m_b = '0; m_result = '0;
    for (int i = 0; i < M; i++) m_buf_a[i] = '0;
    for (int i = 0; i < N; i++) m_buf_b[i] = '0;
  endtask

  task automatic model_step();
    bit was_busy;
    int addr;
    was_busy = m_busy;
    addr     = int'(wr_addr);
    m_done   = 0;
    if (m_busy) begin
      if (m_c >= LEN) begin
        if (corr_valid) begin
          m_result = corr_in; m_done = 1; m_busy = 0;
        end else if (m_c - LEN == TIMEOUT - 1) begin
          m_to = 1; m_busy = 0;
        end
      end
      if (m_busy) m_c++;
    end else if (start) begin
      m_busy = 1; m_to = 0; m_c = 0;
    end
    m_va = m_busy && (m_c < LEN);
    m_vb = m_busy && (m_c >= M) && (m_c < LEN);
    m_a  = (m_busy && m_c < M) ? m_buf_a[m_c] : '0;
    m_b  = m_vb ? m_buf_b[m_c - M] : '0;
    if (wr_en && !was_busy) begin
      if (!wr_sel && addr < M) m_buf_a[addr] = wr_data;
      if (wr_sel && addr < N)  m_buf_b[addr] = wr_data;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_clear();
      else model_step();
    end
  end

  // Compare process: every cycle, just after the active edge.
  initial forever begin
    @(posedge clk);
    #1;
    checkOutput("valid_in_A", valid_in_A, m_va);
    checkOutput("valid_in_B", valid_in_B, m_vb);
    checkOutput("a_out", a_out, m_a);
    checkOutput("b_out", b_out, m_b);
    checkOutput("busy", busy, m_busy);
    checkOutput("done", done, m_done);
    checkOutput("timeout_err", timeout_err, m_to);
    checkOutput("result", result, m_result);
    if (reset) begin
      if (done) begin
        done_count++;
        checkOutput("busy_low_with_done", busy, 0);
      end
      if (busy) busy_cycles++;
      if (capture_on && valid_in_A) begin
        cap_a.push_back(a_out);
        cap_b.push_back(b_out);
        cap_vb.push_back(valid_in_B);
      end
    end
  end

  // Correlator stand-in: answers resp_delay cycles into the wait, optionally with noise before it.
  initial forever begin
    @(negedge clk);
    corr_valid = 1'b0;
    corr_in    = $urandom;
    if (m_busy && m_c >= LEN && (m_c - LEN) == resp_delay) begin
      corr_valid = 1'b1;
      corr_in    = resp_value;
    end else if (spurious_en && (!m_busy || m_c < LEN) && $urandom_range(0, 3) == 0) begin
      corr_valid = 1'b1;
    end
  end

  task automatic applyStimulus(input bit we, input bit sel, input int addr, input int data, input bit st);
    @(negedge clk);
    wr_en   = we;
    wr_sel  = sel;
    wr_addr = addr[AW-1:0];
    wr_data = data[DW-1:0];
    start   = st;
  endtask

  task automatic load6(input int a0, input int a1, input int a2, input int b0, input int b1, input int b2);
    applyStimulus(1, 0, 0, a0, 0);
    applyStimulus(1, 0, 1, a1, 0);
    applyStimulus(1, 0, 2, a2, 0);
    applyStimulus(1, 1, 0, b0, 0);
    applyStimulus(1, 1, 1, b1, 0);
    applyStimulus(1, 1, 2, b2, 0);
    applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("txn_finished", busy, 0);
  endtask

  task automatic clear_capture();
    cap_a.delete(); cap_b.delete(); cap_vb.delete();
  endtask

  task automatic run_txn(input int delay, input logic [31:0] value);
    resp_delay = delay;
    resp_value = value;
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    wait_idle(300);
    applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic check_stream(input int a0, input int a1, input int a2, input int b0, input int b1, input int b2);
    int ea [LEN];
    int eb [LEN];
    ea = '{a0, a1, a2, 0, 0, 0};
    eb = '{0, 0, 0, b0, b1, b2};
    checkOutput("stream_len", cap_a.size(), LEN);
    for (int i = 0; i < LEN && i < cap_a.size(); i++) begin
      checkOutput($sformatf("stream_a[%0d]", i), cap_a[i], 32'(ea[i][DW-1:0]));
      checkOutput($sformatf("stream_b[%0d]", i), cap_b[i], 32'(eb[i][DW-1:0]));
      checkOutput($sformatf("stream_vb[%0d]", i), cap_vb[i], i >= M);
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_valid_in_A", valid_in_A, 0);
    checkOutput("reset_result", result, 0);
    checkOutput("reset_timeout_err", timeout_err, 0);
    reset = 1'b1;

    // Basic transaction: 1*1 + 2*2 + 3*4 = 17
    load6(1, 2, 3, 1, 2, 4);
    done_count = 0; clear_capture(); capture_on = 1;
    run_txn(4, 32'd17);
    capture_on = 0;
    checkOutput("basic_result", result, 32'd17);
    checkOutput("basic_done_count", done_count, 1);
    checkOutput("basic_timeout_err", timeout_err, 0);
    check_stream(1, 2, 3, 1, 2, 4);

    // No answer: busy for the stream plus TIMEOUT wait cycles
    done_count = 0; busy_cycles = 0;
    run_txn(-1, 32'd0);
    checkOutput("timeout_flag", timeout_err, 1);
    checkOutput("timeout_done_count", done_count, 0);
    checkOutput("timeout_result_kept", result, 32'd17);
    checkOutput("timeout_busy_cycles", busy_cycles, LEN + TIMEOUT);

    // Write during SEND_A and restart during SEND_B are both ignored
    done_count = 0; clear_capture(); capture_on = 1;
    resp_delay = 4; resp_value = 32'd17;
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 9, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    wait_idle(300);
    applyStimulus(0, 0, 0, 0, 0);
    capture_on = 0;
    checkOutput("ignore_result", result, 32'd17);
    checkOutput("ignore_done_count", done_count, 1);
    checkOutput("ignore_timeout_cleared", timeout_err, 0);
    check_stream(1, 2, 3, 1, 2, 4);

    // Reset in the middle of SEND_B aborts the transaction
    done_count = 0;
    resp_delay = 4;
    applyStimulus(0, 0, 0, 0, 1);
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort_valid_in_A", valid_in_A, 0);
    checkOutput("abort_valid_in_B", valid_in_B, 0);
    checkOutput("abort_b_out", b_out, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_result", result, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("abort_no_done", done_count, 0);
    load6(1, 2, 3, 1, 2, 4);
    run_txn(4, 32'd17);
    checkOutput("reload_result", result, 32'd17);

    // Negative result arriving on the timeout cycle itself
    load6(-1, -2, -3, 1, 2, 4);
    done_count = 0; busy_cycles = 0; clear_capture(); capture_on = 1;
    run_txn(TIMEOUT - 1, 32'hFFFF_FFEF);
    capture_on = 0;
    checkOutput("neg_result", result, 32'hFFFF_FFEF);
    checkOutput("neg_done_count", done_count, 1);
    checkOutput("neg_timeout_err", timeout_err, 0);
    checkOutput("neg_busy_cycles", busy_cycles, LEN + TIMEOUT);
    check_stream(-1, -2, -3, 1, 2, 4);

    // Randomized traffic: out-of-range writes, stray starts/writes/corr_valid, mixed delays
    spurious_en = 1;
    for (int t = 0; t < 40; t++) begin
      int pick;
      for (int k = 0; k < 6; k++)
        applyStimulus(1, $urandom_range(0, 1), $urandom_range(0, 3), $urandom, 0);
      pick = $urandom_range(0, 9);
      if (pick <= 6)      resp_delay = $urandom_range(0, 10);
      else if (pick == 7) resp_delay = TIMEOUT - 1;
      else if (pick == 8) resp_delay = -1;
      else                resp_delay = TIMEOUT + 5;
      resp_value = $urandom;
      applyStimulus(0, 0, 0, 0, 1);
      for (int n = 0; n < 300; n++) begin
        applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 3),
                      $urandom, $urandom_range(0, 7) == 0);
        if (!busy) break;
      end
      applyStimulus(0, 0, 0, 0, 0);
      wait_idle(300);
    end
    spurious_en = 0;
    repeat (3) applyStimulus(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pwxc_stream_driver.md
PWXC_STREAM_DRIVER -- requirements
Module: pwxc_stream_driver

Interface
REQ-001 Parameters SHALL be: M, default 3, length of sequence A; N, default 3, length of sequence B; DATA_WIDTH, default 16, signed sample width; TIMEOUT, default 64, maximum wait cycles for a result.
REQ-002 AW SHALL equal $clog2(max(M,N)), minimum 1, and SHALL be the width of wr_addr.
REQ-003 Ports SHALL be, in this order:
  clk  input  1  single clock; all state updates on rising edge
  reset  input  1  asynchronous, active-low reset
  wr_en  input  1  buffer write strobe
  wr_sel  input  1  write target: 0 = buffer A, 1 = buffer B
  wr_addr  input  AW  sample index
  wr_data  input  DATA_WIDTH  signed sample
  start  input  1  begin one stream/collect transaction
  valid_in_A  output  1  to correlator: A phase valid
  valid_in_B  output  1  to correlator: B phase valid
  a_out  output  DATA_WIDTH  to correlator: A sample
  b_out  output  DATA_WIDTH  to correlator: B sample
  corr_valid  input  1  from correlator valid_out
  corr_in  input  2*DATA_WIDTH  from correlator correlation_out, signed
  busy  output  1  transaction in progress
  result  output  2*DATA_WIDTH  captured correlation, signed
  done  output  1  one-cycle pulse when result is captured
  timeout_err  output  1  sticky timeout flag

Function
REQ-004 Buffers A[0..M-1] and B[0..N-1] SHALL be registered arrays written on wr_en while busy=0; a write with wr_addr >= M (wr_sel=0) or >= N (wr_sel=1) SHALL be ignored.
REQ-005 A write with wr_en=1 while busy=1 SHALL be ignored; buffer contents SHALL be unchanged.
REQ-006 FSM states SHALL be IDLE, SEND_A, SEND_B, WAIT_RES; all outputs SHALL be registered.
REQ-007 IDLE: on start=1, go to SEND_A, clear index counter to 0, clear timeout_err, set busy=1 from the next cycle.
REQ-008 SEND_A: for M consecutive cycles drive valid_in_A=1, valid_in_B=0, a_out=A[i], b_out=0, i=0..M-1; after i=M-1 go to SEND_B with i=0.
REQ-009 SEND_B: for N consecutive cycles drive valid_in_A=1, valid_in_B=1, a_out=0, b_out=B[i]; after i=N-1 go to WAIT_RES.
REQ-010 valid_in_A SHALL therefore be high for exactly M+N contiguous cycles and valid_in_B for exactly the last N of them, with no gap between phases.
REQ-011 WAIT_RES: valid_in_A=valid_in_B=0, a_out=b_out=0; a wait counter SHALL increment each cycle from 0.
REQ-012 In WAIT_RES, corr_valid=1 SHALL latch corr_in into result, pulse done=1 for one cycle, and return to IDLE with busy=0 on the same edge.
REQ-013 If the wait counter reaches TIMEOUT-1 without corr_valid, the FSM SHALL return to IDLE, set timeout_err=1, leave result unchanged and not pulse done.
REQ-014 If corr_valid and timeout occur in the same cycle, corr_valid SHALL win: result captured, done pulsed, timeout_err stays 0.
REQ-015 corr_valid asserted in IDLE, SEND_A or SEND_B SHALL be ignored.
REQ-016 start while busy=1 SHALL be ignored; start in the same cycle the FSM returns to IDLE SHALL be ignored (accepted only in IDLE).
REQ-017 timeout_err SHALL remain set until the next accepted start or reset.
REQ-018 result SHALL hold its last captured value across transactions until overwritten.

Reset
REQ-019 reset=0 SHALL asynchronously force state IDLE, counters 0, valid_in_A=valid_in_B=0, a_out=b_out=0, busy=0, done=0, timeout_err=0, result=0.
REQ-020 Buffers A and B SHALL be cleared to 0 by reset.
REQ-021 Reset asserted mid-transaction SHALL abort it immediately; no done pulse SHALL follow deassertion.

Verification
REQ-022 Load A={1,2,3}, B={1,2,4}; start; correlator model returns 17 four cycles after SEND_B ends -> result=17, done pulses once, busy falls same cycle, timeout_err=0.
REQ-023 Same load; capture output stream -> valid_in_A high 6 cycles, valid_in_B high last 3, a_out sequence 1,2,3,0,0,0, b_out 0,0,0,1,2,4.
REQ-024 Start with corr_valid never asserted, TIMEOUT=64 -> timeout_err=1 after 64 WAIT_RES cycles, done never pulses, result unchanged.
REQ-025 start pulsed again during SEND_B and wr_en writing A[0]=9 during SEND_A -> both ignored; stream and result identical to REQ-022.
REQ-026 reset=0 for one cycle during SEND_B -> all outputs 0 immediately, no done afterward; reload, restart -> result=17.
REQ-027 A={-1,-2,-3}, B={1,2,4}, model returns -17 -> result=-17 sign-correct in 2*DATA_WIDTH bits; corr_valid coincident with timeout cycle -> done=1, timeout_err=0.
